// File: rtl/adder32_arb_pkg.sv
// adder32_arb_pkg: FSM state encoding and result width shared by the adder32 arbiter.
package adder32_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam int RES_WIDTH = 33;
endpackage

// File: rtl/adder32.sv
// adder32: combinational 32-bit adder, carry-out in bit 32 of r.
module adder32
  import adder32_arb_pkg::*;
(
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  output logic [RES_WIDTH-1:0] r
);
  assign r = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder32_arbiter.sv
// adder32_arbiter: round-robin sharing of one adder32 among NREQ requesters; ADDER32_ARB_STATS_EN adds op_count.
module adder32_arbiter
  import adder32_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_WIDTH-1:0]     res_r,
  output logic [$clog2(NREQ)-1:0]  res_id
`ifdef ADDER32_ARB_STATS_EN
  ,
  output logic [31:0]              op_count
`endif
);
  localparam int IDW = $clog2(NREQ);
  state_t               state;
  logic [IDW-1:0]       ptr, id_q, g;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [RES_WIDTH-1:0] sum;
  logic                 grant;
  // first set bit of v at or after p, wrapping around
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    int idx;
    rr_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) rr_pick = IDW'(idx);
    end
  endfunction
  assign g         = rr_pick(req_valid, ptr);
  assign grant     = (state == IDLE) && (|req_valid) && !rst;
  assign req_ready = grant ? NREQ'(1) << g : '0;
  assign res_valid = (state == DONE);
  adder32 u_add (.a(op_a), .b(op_b), .r(sum));
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      id_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_r  <= '0;
      res_id <= '0;
    end else begin
      state <= grant ? EXEC : (state == EXEC) ? DONE : (state == DONE && res_ready) ? IDLE : state;
      if (grant) begin
        op_a <= req_a[WIDTH*int'(g) +: WIDTH];
        op_b <= req_b[WIDTH*int'(g) +: WIDTH];
        id_q <= g;
        ptr  <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
      end
      if (state == EXEC) begin
        res_r  <= sum;
        res_id <= id_q;
      end
    end
  end
`ifdef ADDER32_ARB_STATS_EN
  always_ff @(posedge clk)
    if (rst) op_count <= '0;
    else if (state == DONE && res_ready) op_count <= op_count + 1'b1;
`endif
endmodule

// File: tb/tb_adder32_arbiter.sv
// tb_adder32_arbiter: scoreboard bench for adder32_arbiter (NREQ=4).
module tb_adder32_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0, req_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [32:0]  res_r;
  logic [1:0]   res_id;
`ifdef ADDER32_ARB_STATS_EN
  logic [31:0]  op_count;
`endif
  int errors = 0, checks = 0;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  adder32_arbiter #(.NREQ(4), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_id(res_id)
`ifdef ADDER32_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic push_exp(input int i);
    sb.push_back({2'(i), {1'b0, req_a[32*i +: 32]} + {1'b0, req_b[32*i +: 32]}});
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 50);
  endtask

  // walks EXEC and DONE after a grant cycle, recording what the DUT shows
  task automatic finish_op(input logic [3:0] v_after, input bit scr, output logic [3:0] rdy_x,
                           output logic rv_x, output logic rv_d, output logic [34:0] exp, output logic [34:0] got);
    @(posedge clk); #1;
    req_valid = v_after;
    if (scr) begin req_a = ~req_a; req_b = ~req_b; end
    @(negedge clk);
    rdy_x = req_ready;
    rv_x  = res_valid;
    @(negedge clk);
    rv_d = res_valid;
    got  = {res_id, res_r};
    exp  = 'x;
    if (sb.size() != 0) exp = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    checks++; if ({res_id, res_r} !== 35'b0) begin errors++; $display("FAIL reset_res: got %h want 0", {res_id, res_r}); end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL idle_noreq: ready=%b valid=%b want 0000 0", req_ready, res_valid); end
  endtask

  task automatic test_single();
    logic [3:0] rx; logic vx, vd; logic [34:0] e, g; int n;
    @(posedge clk); #1;
    set_op(2, 32'h5, 32'h3);
    req_valid = 4'b0100;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0100 || n != 1) begin errors++; $display("FAIL single_grant: got %b after %0d want 0100 after 1", req_ready, n); end
    push_exp(2);
    finish_op(4'b0, 1'b1, rx, vx, vd, e, g);
    checks++; if (rx !== 4'b0 || vx !== 1'b0) begin errors++; $display("FAIL single_exec: ready=%b valid=%b want 0000 0", rx, vx); end
    checks++; if (vd !== 1'b1) begin errors++; $display("FAIL single_latency: res_valid=%b want 1", vd); end
    checks++; if (g !== e || g !== {2'd2, 33'h8}) begin errors++; $display("FAIL single_res: got %h want %h", g, {2'd2, 33'h8}); end
  endtask

  task automatic test_carry();
    logic [3:0] rx; logic vx, vd; logic [34:0] e, g; int n;
    @(posedge clk); #1;
    set_op(3, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b1000;
    wait_grant(n);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL carry_grant: got %b want 1000", req_ready); end
    push_exp(3);
    finish_op(4'b0, 1'b0, rx, vx, vd, e, g);
    checks++; if (vd !== 1'b1 || g !== e || g[32:0] !== 33'h1_0000_0000) begin errors++; $display("FAIL carry_res: got %h want %h", g, e); end
  endtask

  task automatic test_round_robin();
    logic [3:0] rx; logic vx, vd; logic [34:0] e, g; int n;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_op(i, 32'h1000_0001 * (i + 1), 32'h0F0F_0F0F + 32'(i * 7));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      checks++; if (req_ready !== 4'(1 << (k % 4)) || n != 1) begin errors++; $display("FAIL rr_grant%0d: got %b after %0d want %b after 1", k, req_ready, n, 4'(1 << (k % 4))); end
      push_exp(k % 4);
      finish_op((k == 4) ? 4'b0 : 4'hF, 1'b0, rx, vx, vd, e, g);
      checks++; if (vd !== 1'b1 || rx !== 4'b0 || g !== e) begin errors++; $display("FAIL rr_res%0d: got %h want %h", k, g, e); end
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0] rx; logic vx, vd; logic [34:0] e, g; int n, bad;
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 4'hF;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    push_exp(1);
    finish_op(4'hF, 1'b0, rx, vx, vd, e, g);
    checks++; if (vd !== 1'b1 || g !== e) begin errors++; $display("FAIL bp_res: got %h want %h", g, e); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready !== 4'b0 || res_valid !== 1'b1 || {res_id, res_r} !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0100 || n != 2) begin errors++; $display("FAIL bp_resume: got %b after %0d want 0100 after 2", req_ready, n); end
    push_exp(2);
    finish_op(4'b0, 1'b0, rx, vx, vd, e, g);
    checks++; if (vd !== 1'b1 || g !== e) begin errors++; $display("FAIL bp_next: got %h want %h", g, e); end
  endtask

  task automatic test_reset_mid_exec();
    logic [3:0] rx; logic vx, vd; logic [34:0] e, g; int n, bad;
    @(posedge clk); #1;
    set_op(0, 32'h0000_DEAD, 32'h0000_BEEF);
    req_valid = 4'b0001;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_pre_grant: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_exec_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_ready: ready=%b valid=%b want 0000 0", req_ready, res_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || {res_id, res_r} !== 35'b0) begin errors++; $display("FAIL rst_discard: valid=%b res=%h want 0 0", res_valid, {res_id, res_r}); end
    bad = 0;
    repeat (4) begin @(negedge clk); if (res_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_result: %0d result cycles want 0", bad); end
    @(posedge clk); #1;
    set_op(3, 32'h1234_5678, 32'h1111_1111);
    req_valid = 4'b1001;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr: got %b want 0001", req_ready); end
    push_exp(0);
    finish_op(4'b0, 1'b0, rx, vx, vd, e, g);
    checks++; if (vd !== 1'b1 || g !== e) begin errors++; $display("FAIL rst_after: got %h want %h", g, e); end
  endtask

  task automatic test_random();
    logic [3:0] rx; logic vx, vd; logic [34:0] e, g; int n, i;
    logic [31:0] a, b;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a = $urandom(0);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      i = $urandom_range(3, 0);
      a = $urandom;
      b = $urandom;
      set_op(i, a, b);
      req_valid = 4'(1 << i);
      wait_grant(n);
      checks++; if (req_ready !== 4'(1 << i)) begin errors++; $display("FAIL rand_grant%0d: got %b want %b", k, req_ready, 4'(1 << i)); end
      push_exp(i);
      finish_op(4'b0, 1'b1, rx, vx, vd, e, g);
      checks++; if (vd !== 1'b1 || g !== e || g[32:0] !== {1'b0, a} + {1'b0, b}) begin errors++; $display("FAIL rand_res%0d: got %h want %h", k, g, e); end
    end
`ifdef ADDER32_ARB_STATS_EN
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (op_count !== 32'd1000) begin errors++; $display("FAIL op_count: got %0d want 1000", op_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
